// File: rtl/phdet_pkg.sv
// rtl/phdet_pkg.sv - shared encodings for the phase-error monitor
//
// Contents:
//   disp_mode_e   display statistic select (avg / min / max / last sample)
//   LOCK_CNT_W    width of the per-channel consecutive-window lock counter
//   lock_state_e  per-channel lock FSM states
package phdet_pkg;

   typedef enum logic [1:0] {
      DISP_AVG  = 2'd0,
      DISP_MIN  = 2'd1,
      DISP_MAX  = 2'd2,
      DISP_LAST = 2'd3
   } disp_mode_e;

   localparam int LOCK_CNT_W = 4;

   typedef enum logic {
      LOCK_OFF = 1'b0,
      LOCK_ON  = 1'b1
   } lock_state_e;

endpackage

// File: rtl/phase_err_channel.sv
// rtl/phase_err_channel.sv - one channel of window statistics plus lock detector
//
// Ports:
//   fpga_clk_i   in   clock, all state rising-edge
//   reset_i      in   asynchronous active-high reset
//   clear_i      in   synchronous clear of window and lock state (outputs held)
//   err_i        in   ERR_W signed error sample
//   err_valid_i  in   sample strobe
//   avg_o        out  last completed window average (floor), signed
//   min_o        out  last completed window minimum, signed
//   max_o        out  last completed window maximum, signed
//   last_o       out  most recent accepted sample
//   win_done_o   out  one-cycle pulse when a window completes
//   lock_o       out  lock flag with hysteresis
module phase_err_channel
   import phdet_pkg::*;
#(
   parameter int ERR_W        = 8,
   parameter int LOG2_WIN     = 4,
   parameter int LOCK_THRESH  = 2,
   parameter int LOCK_WINDOWS = 4
) (
   input  logic             fpga_clk_i,
   input  logic             reset_i,
   input  logic             clear_i,
   input  logic [ERR_W-1:0] err_i,
   input  logic             err_valid_i,
   output logic [ERR_W-1:0] avg_o,
   output logic [ERR_W-1:0] min_o,
   output logic [ERR_W-1:0] max_o,
   output logic [ERR_W-1:0] last_o,
   output logic             win_done_o,
   output logic             lock_o
);

   localparam int ACC_W = ERR_W + LOG2_WIN;
   localparam logic [ERR_W-1:0] POS_MAX = {1'b0, {(ERR_W-1){1'b1}}};
   localparam logic [ERR_W-1:0] NEG_MAX = {1'b1, {(ERR_W-1){1'b0}}};
   localparam logic [LOCK_CNT_W-1:0] LOCK_TARGET = LOCK_CNT_W'(LOCK_WINDOWS);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;
   logic [LOG2_WIN-1:0]     cnt;
   logic signed [ERR_W-1:0] sample;
   logic signed [ERR_W-1:0] run_min;
   logic signed [ERR_W-1:0] run_max;
   logic signed [ERR_W-1:0] new_min;
   logic signed [ERR_W-1:0] new_max;
   logic                    win_end;

   assign sample  = $signed(err_i);
   assign sum     = acc + $signed({{LOG2_WIN{err_i[ERR_W-1]}}, err_i});
   assign new_min = (sample < run_min) ? sample : run_min;
   assign new_max = (sample > run_max) ? sample : run_max;
   assign win_end = err_valid_i && (cnt == '1);

   always_ff @(posedge fpga_clk_i or posedge reset_i) begin
      if (reset_i) begin
         acc        <= '0;
         cnt        <= '0;
         run_min    <= POS_MAX;
         run_max    <= NEG_MAX;
         last_o     <= '0;
         avg_o      <= '0;
         min_o      <= '0;
         max_o      <= '0;
         win_done_o <= 1'b0;
      end else begin
         win_done_o <= 1'b0;
         if (clear_i) begin
            // A sample arriving with clear is dropped; last_o and results are held.
            acc     <= '0;
            cnt     <= '0;
            run_min <= POS_MAX;
            run_max <= NEG_MAX;
         end else if (err_valid_i) begin
            last_o <= err_i;
            if (win_end) begin
               // Upper bits of the sum are the arithmetic shift (floor divide).
               avg_o      <= sum[ACC_W-1:LOG2_WIN];
               min_o      <= new_min;
               max_o      <= new_max;
               win_done_o <= 1'b1;
               acc        <= '0;
               cnt        <= '0;
               run_min    <= POS_MAX;
               run_max    <= NEG_MAX;
            end else begin
               acc     <= sum;
               cnt     <= cnt + 1'b1;
               run_min <= new_min;
               run_max <= new_max;
            end
         end
      end
   end

   // Lock detector: runs the cycle after win_done_o, looking at the fresh avg_o.
   lock_state_e           lock_state;
   lock_state_e           lock_state_nxt;
   logic [LOCK_CNT_W-1:0] lock_cnt;
   logic [LOCK_CNT_W-1:0] lock_cnt_nxt;
   logic [LOCK_CNT_W-1:0] lock_inc;
   logic [ERR_W:0]        avg_ext;
   logic [ERR_W:0]        avg_mag;
   logic                  in_thresh;

   // One extra bit so the most negative average has a representable magnitude.
   assign avg_ext   = {avg_o[ERR_W-1], avg_o};
   assign avg_mag   = avg_ext[ERR_W] ? (~avg_ext + 1'b1) : avg_ext;
   assign in_thresh = (avg_mag <= (ERR_W+1)'(LOCK_THRESH));
   assign lock_inc  = (lock_cnt == LOCK_TARGET) ? lock_cnt : lock_cnt + 1'b1;

   always_ff @(posedge fpga_clk_i or posedge reset_i) begin
      if (reset_i) begin
         lock_state <= LOCK_OFF;
         lock_cnt   <= '0;
      end else begin
         lock_state <= lock_state_nxt;
         lock_cnt   <= lock_cnt_nxt;
      end
   end

   always_comb begin
      lock_state_nxt = lock_state;
      lock_cnt_nxt   = lock_cnt;
      if (clear_i) begin
         lock_state_nxt = LOCK_OFF;
         lock_cnt_nxt   = '0;
      end else if (win_done_o) begin
         if (in_thresh) begin
            lock_cnt_nxt = lock_inc;
            if (lock_inc == LOCK_TARGET) begin
               lock_state_nxt = LOCK_ON;
            end
         end else begin
            // Any out-of-threshold window drops lock immediately.
            lock_cnt_nxt   = '0;
            lock_state_nxt = LOCK_OFF;
         end
      end
   end

   assign lock_o = (lock_state == LOCK_ON);

endmodule

// File: rtl/phase_error_monitor.sv
// rtl/phase_error_monitor.sv - multi-channel phase-error statistics, lock flags and display mux
//
// Ports:
//   fpga_clk_i   in   sole clock, all state rising-edge
//   reset_i      in   asynchronous active-high reset
//   clear_i      in   synchronous clear of all window and lock state
//   err_i        in   NUM_CH packed signed samples, channel c at [c*ERR_W +: ERR_W]
//   err_valid_i  in   per-channel sample strobe
//   sel_i        in   display channel select (out of range shows 0)
//   mode_i       in   display statistic: avg / min / max / last sample
//   avg_o        out  per-channel last completed window average
//   min_o        out  per-channel last completed window minimum
//   max_o        out  per-channel last completed window maximum
//   win_done_o   out  per-channel window-complete pulse
//   lock_o       out  per-channel lock flag
//   disp_o       out  registered selected statistic
module phase_error_monitor
   import phdet_pkg::*;
#(
   parameter int NUM_CH       = 4,
   parameter int ERR_W        = 8,
   parameter int LOG2_WIN     = 4,
   parameter int LOCK_THRESH  = 2,
   parameter int LOCK_WINDOWS = 4,
   localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    fpga_clk_i,
   input  logic                    reset_i,
   input  logic                    clear_i,
   input  logic [NUM_CH*ERR_W-1:0] err_i,
   input  logic [NUM_CH-1:0]       err_valid_i,
   input  logic [SEL_W-1:0]        sel_i,
   input  logic [1:0]              mode_i,
   output logic [NUM_CH*ERR_W-1:0] avg_o,
   output logic [NUM_CH*ERR_W-1:0] min_o,
   output logic [NUM_CH*ERR_W-1:0] max_o,
   output logic [NUM_CH-1:0]       win_done_o,
   output logic [NUM_CH-1:0]       lock_o,
   output logic [ERR_W-1:0]        disp_o
);

   // Select space is padded to a power of two so sel_i never indexes past the
   // array; padding slots read as zero.
   localparam int NUM_SLOT = 1 << SEL_W;

   logic [ERR_W-1:0] avg_s  [NUM_SLOT];
   logic [ERR_W-1:0] min_s  [NUM_SLOT];
   logic [ERR_W-1:0] max_s  [NUM_SLOT];
   logic [ERR_W-1:0] last_s [NUM_SLOT];

   for (genvar c = 0; c < NUM_SLOT; c++) begin : g_slot
      if (c < NUM_CH) begin : g_ch
         phase_err_channel #(
            .ERR_W        (ERR_W),
            .LOG2_WIN     (LOG2_WIN),
            .LOCK_THRESH  (LOCK_THRESH),
            .LOCK_WINDOWS (LOCK_WINDOWS)
         ) u_ch (
            .fpga_clk_i  (fpga_clk_i),
            .reset_i     (reset_i),
            .clear_i     (clear_i),
            .err_i       (err_i[c*ERR_W +: ERR_W]),
            .err_valid_i (err_valid_i[c]),
            .avg_o       (avg_o[c*ERR_W +: ERR_W]),
            .min_o       (min_o[c*ERR_W +: ERR_W]),
            .max_o       (max_o[c*ERR_W +: ERR_W]),
            .last_o      (last_s[c]),
            .win_done_o  (win_done_o[c]),
            .lock_o      (lock_o[c])
         );
         assign avg_s[c] = avg_o[c*ERR_W +: ERR_W];
         assign min_s[c] = min_o[c*ERR_W +: ERR_W];
         assign max_s[c] = max_o[c*ERR_W +: ERR_W];
      end else begin : g_pad
         assign avg_s[c]  = '0;
         assign min_s[c]  = '0;
         assign max_s[c]  = '0;
         assign last_s[c] = '0;
      end
   end

   always_ff @(posedge fpga_clk_i or posedge reset_i) begin
      if (reset_i) begin
         disp_o <= '0;
      end else if (int'(sel_i) >= NUM_CH) begin
         disp_o <= '0;
      end else begin
         case (mode_i)
            DISP_AVG:  disp_o <= avg_s[sel_i];
            DISP_MIN:  disp_o <= min_s[sel_i];
            DISP_MAX:  disp_o <= max_s[sel_i];
            DISP_LAST: disp_o <= last_s[sel_i];
         endcase
      end
   end

endmodule

// File: tb/tb_phase_error_monitor.sv
// tb/tb_phase_error_monitor.sv - self-checking bench for phase_error_monitor
module tb_phase_error_monitor;

   // Three channels so a 2-bit select can address an absent channel.
   localparam int NUM_CH       = 3;
   localparam int ERR_W        = 8;
   localparam int LOG2_WIN     = 4;
   localparam int LOCK_THRESH  = 2;
   localparam int LOCK_WINDOWS = 4;
   localparam int SEL_W        = 2;
   localparam int WIN          = 1 << LOG2_WIN;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    clr;
   logic [NUM_CH*ERR_W-1:0] err;
   logic [NUM_CH-1:0]       vld;
   logic [SEL_W-1:0]        sel;
   logic [1:0]              mode;
   logic [NUM_CH*ERR_W-1:0] avg_o;
   logic [NUM_CH*ERR_W-1:0] min_o;
   logic [NUM_CH*ERR_W-1:0] max_o;
   logic [NUM_CH-1:0]       win_done_o;
   logic [NUM_CH-1:0]       lock_o;
   logic [ERR_W-1:0]        disp_o;

   phase_error_monitor #(
      .NUM_CH       (NUM_CH),
      .ERR_W        (ERR_W),
      .LOG2_WIN     (LOG2_WIN),
      .LOCK_THRESH  (LOCK_THRESH),
      .LOCK_WINDOWS (LOCK_WINDOWS)
   ) dut (
      .fpga_clk_i  (clk),
      .reset_i     (rst),
      .clear_i     (clr),
      .err_i       (err),
      .err_valid_i (vld),
      .sel_i       (sel),
      .mode_i      (mode),
      .avg_o       (avg_o),
      .min_o       (min_o),
      .max_o       (max_o),
      .win_done_o  (win_done_o),
      .lock_o      (lock_o),
      .disp_o      (disp_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int a;
      int b;
      int avg;
      int mn;
      int mx;
   } win_t;

   typedef struct {
      int sel;
      int mode;
      int exp;
   } disp_vec_t;

   int   tests = 0;
   int   fails = 0;
   win_t sb[$];
   int   done_cnt [NUM_CH];
   int   exp_done [NUM_CH];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int sx(input logic [ERR_W-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic int ch_avg(input int c);
      return sx(avg_o[c*ERR_W +: ERR_W]);
   endfunction

   function automatic int ch_min(input int c);
      return sx(min_o[c*ERR_W +: ERR_W]);
   endfunction

   function automatic int ch_max(input int c);
      return sx(max_o[c*ERR_W +: ERR_W]);
   endfunction

   // Scoreboard consumer: every window pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (win_done_o[c]) begin
               done_cnt[c]++;
               if (sb.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_win_done: got pulse on ch%0d expected none", c);
               end else begin
                  win_t e;
                  e = sb.pop_front();
                  check("win_channel", c, e.ch);
                  check("win_avg", ch_avg(c), e.avg);
                  check("win_min", ch_min(c), e.mn);
                  check("win_max", ch_max(c), e.mx);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int c, input int v, input bit with_clear);
      err = '0;
      err[c*ERR_W +: ERR_W] = ERR_W'(v);
      vld = NUM_CH'(1 << c);
      clr = with_clear;
      tick();
      vld = '0;
      clr = 1'b0;
   endtask

   // Sixteen samples alternating a,b starting with a; expectation queued before the last.
   task automatic run_window(input int c, input int a, input int b,
                             input int avg, input int mn, input int mx);
      win_t e;
      for (int i = 0; i < WIN; i++) begin
         if (i == WIN - 1) begin
            e.ch  = c;
            e.a   = a;
            e.b   = b;
            e.avg = avg;
            e.mn  = mn;
            e.mx  = mx;
            sb.push_back(e);
            exp_done[c]++;
         end
         feed(c, (i % 2 == 0) ? a : b, 1'b0);
      end
   endtask

   win_t      wtab [6];
   disp_vec_t dtab [8];
   int        prev_disp;

   initial begin
      wtab[0] = '{0,    3,    3,    3,    3,    3};
      wtab[1] = '{0, -128,  127,   -1, -128,  127};
      wtab[2] = '{0,   -1,    0,   -1,   -1,    0};
      wtab[3] = '{1,   -4,    6,    1,   -4,    6};
      wtab[4] = '{2,  100,  101,  100,  100,  101};
      wtab[5] = '{2, -100, -101, -101, -101, -100};

      dtab[0] = '{1, 1,   -4};
      dtab[1] = '{1, 2,    6};
      dtab[2] = '{1, 0,    1};
      dtab[3] = '{1, 3,    6};
      dtab[4] = '{3, 0,    0};
      dtab[5] = '{2, 0, -101};
      dtab[6] = '{2, 2, -100};
      dtab[7] = '{0, 1,   -1};

      for (int c = 0; c < NUM_CH; c++) begin
         done_cnt[c] = 0;
         exp_done[c] = 0;
      end

      rst  = 1'b1;
      clr  = 1'b0;
      err  = '0;
      vld  = '0;
      sel  = '0;
      mode = 2'd0;
      tick();
      tick();
      check("reset_avg", int'(avg_o), 0);
      check("reset_min", int'(min_o), 0);
      check("reset_max", int'(max_o), 0);
      check("reset_win_done", int'(win_done_o), 0);
      check("reset_lock", int'(lock_o), 0);
      check("reset_disp", int'(disp_o), 0);
      rst = 1'b0;
      tick();

      // Window statistics table.
      for (int r = 0; r < 6; r++) begin
         run_window(wtab[r].ch, wtab[r].a, wtab[r].b, wtab[r].avg, wtab[r].mn, wtab[r].mx);
         check("win_done_pulse", int'(win_done_o), 1 << wtab[r].ch);
         tick();
         check("win_done_low", int'(win_done_o), 0);
         check("win_done_count", done_cnt[wtab[r].ch], exp_done[wtab[r].ch]);
         if (r == 0) begin
            check("idle_ch1_avg", ch_avg(1), 0);
            check("idle_ch2_max", ch_max(2), 0);
         end
      end

      // Display mux: unchanged before the edge, new value one cycle later.
      prev_disp = sx(disp_o);
      check("disp_tracks_ch0_avg", prev_disp, -1);
      for (int r = 0; r < 8; r++) begin
         sel  = SEL_W'(dtab[r].sel);
         mode = 2'(dtab[r].mode);
         #1;
         check("disp_latency", sx(disp_o), prev_disp);
         tick();
         check("disp_value", sx(disp_o), dtab[r].exp);
         prev_disp = dtab[r].exp;
      end

      // Lock rise after LOCK_WINDOWS in-threshold windows on ch0.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("lock_after_clear", int'(lock_o), 0);
      for (int k = 0; k < LOCK_WINDOWS; k++) begin
         run_window(0, 1, 1, 1, 1, 1);
         check("lock_at_t1", int'(lock_o[0]), 0);
         tick();
         check("lock_at_t2", int'(lock_o[0]), (k == LOCK_WINDOWS - 1) ? 1 : 0);
      end

      // Out-of-threshold window drops lock one cycle after its pulse.
      run_window(0, 5, 5, 5, 5, 5);
      check("lock_hold_t1", int'(lock_o[0]), 1);
      tick();
      check("lock_drop_t2", int'(lock_o[0]), 0);

      // Three good windows then a bad one: never reaches lock.
      for (int k = 0; k < 3; k++) begin
         run_window(0, -2, -2, -2, -2, -2);
         tick();
         check("lock_partial", int'(lock_o[0]), 0);
      end
      run_window(0, 3, 3, 3, 3, 3);
      tick();
      check("lock_broken", int'(lock_o[0]), 0);

      // Relock with average -1, then clear mid-window.
      for (int k = 0; k < LOCK_WINDOWS; k++) begin
         run_window(0, -1, -1, -1, -1, -1);
         tick();
      end
      check("relock", int'(lock_o[0]), 1);
      for (int i = 0; i < 9; i++) feed(0, 1, 1'b0);
      feed(0, 1, 1'b1);
      check("clear_drops_lock", int'(lock_o[0]), 0);
      check("clear_holds_avg", ch_avg(0), -1);
      run_window(0, 7, 7, 7, 7, 7);
      tick();
      check("post_clear_lock", int'(lock_o[0]), 0);

      // Asynchronous reset in the middle of a window, off the clock edge.
      for (int i = 0; i < 5; i++) feed(0, 50, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      check("async_rst_avg", int'(avg_o), 0);
      check("async_rst_min", int'(min_o), 0);
      check("async_rst_max", int'(max_o), 0);
      check("async_rst_disp", int'(disp_o), 0);
      #7;
      rst = 1'b0;
      tick();
      run_window(0, -5, -5, -5, -5, -5);
      tick();

      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
